// File: rtl/motor_dense_l2_pkg.sv
// motor_dense_l2 shared constants: dims, fixed-point widths,
// trained layer-2 weights/biases (ap_fixed<21,7>) and FSM states.
package motor_dense_l2_pkg;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 4;
  localparam int W_DATA = 21;
  localparam int F_DATA = 14;
  localparam int ACC_W  = 2*W_DATA + 3;

  // W[j][i] sits at bit (4j+i)*W_DATA; first literal is W[3][3]
  localparam logic [N_OUT*N_IN*W_DATA-1:0] WEIGHTS_DEF = {
    21'h1FF5A9, 21'h000170, 21'h00068D, 21'h1FEE7F,
    21'h002B4C, 21'h1FFA03, 21'h000911, 21'h1FD6B2,
    21'h0003E1, 21'h000C08, 21'h1FF215, 21'h001A77,
    21'h1FE8D0, 21'h00052C, 21'h1FC2B1, 21'h000F3A
  };

  // b[j] at bit j*W_DATA; first literal is b[3]
  localparam logic [N_OUT*W_DATA-1:0] BIASES_DEF = {
    21'h1FF9C4, 21'h000B21, 21'h1FE310, 21'h0003A7
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/motor_mac_s21.sv
// Signed 21x21 MAC into a 45-bit accumulator; clr reloads the bias.
// Ports: clk/rst_n, en, clr, a, w, bias in; q_next = acc_next[34:14].
module motor_mac_s21
  import motor_dense_l2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [W_DATA-1:0] a,
  input  logic signed [W_DATA-1:0] w,
  input  logic signed [W_DATA-1:0] bias,
  output logic        [W_DATA-1:0] q_next
);

  logic signed [2*W_DATA-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    acc_nx;

  always_comb begin
    prod   = a * w;
    // bias has F_DATA frac bits, products 2*F_DATA: align first
    base   = clr ? (ACC_W'(bias) <<< F_DATA) : acc;
    acc_nx = base + ACC_W'(prod);
    q_next = acc_nx[F_DATA+W_DATA-1:F_DATA];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nx;
    end
  end

endmodule

// File: rtl/motor_dense_l2_seq.sv
// Sequential 4x4 dense layer, one shared MAC, ap_ctrl_hs handshake.
// Ports: ap_clk/ap_rst_n, ap_start/ready/idle/done, p_read0..3, ap_return_0..3.
module motor_dense_l2_seq
  import motor_dense_l2_pkg::*;
#(
  parameter logic [N_OUT*N_IN*W_DATA-1:0] WEIGHTS = WEIGHTS_DEF,
  parameter logic [N_OUT*W_DATA-1:0]      BIASES  = BIASES_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic [W_DATA-1:0] p_read0,
  input  logic [W_DATA-1:0] p_read1,
  input  logic [W_DATA-1:0] p_read2,
  input  logic [W_DATA-1:0] p_read3,
  output logic [W_DATA-1:0] ap_return_0,
  output logic [W_DATA-1:0] ap_return_1,
  output logic [W_DATA-1:0] ap_return_2,
  output logic [W_DATA-1:0] ap_return_3
);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        i_q;
  logic [1:0]        j_q;
  logic [W_DATA-1:0] x_r    [N_IN];
  logic [W_DATA-1:0] shadow [N_OUT];
  logic [W_DATA-1:0] w_op;
  logic [W_DATA-1:0] b_op;
  logic [W_DATA-1:0] q_next;
  logic              mac_en;
  logic              last;

  assign w_op   = WEIGHTS[32'({j_q, i_q})*W_DATA +: W_DATA];
  assign b_op   = BIASES[32'(j_q)*W_DATA +: W_DATA];
  assign mac_en = (state == S_MAC);
  assign last   = mac_en && (i_q == 2'd3) && (j_q == 2'd3);

  motor_mac_s21 u_mac (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .en     (mac_en),
    .clr    (i_q == 2'd0),
    .a      (x_r[i_q]),
    .w      (w_op),
    .bias   (b_op),
    .q_next (q_next)
  );

  always_comb begin
    state_nx = state;
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_nx = S_MAC;
      end
      S_MAC: begin
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        ap_done  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign ap_ready = ap_idle & ap_start;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      ap_return_0 <= '0;
      ap_return_1 <= '0;
      ap_return_2 <= '0;
      ap_return_3 <= '0;
      for (int k = 0; k < N_IN; k++) x_r[k] <= '0;
      for (int k = 0; k < N_OUT; k++) shadow[k] <= '0;
    end else begin
      state <= state_nx;
      if (ap_ready) begin
        x_r[0] <= p_read0;
        x_r[1] <= p_read1;
        x_r[2] <= p_read2;
        x_r[3] <= p_read3;
        i_q    <= '0;
        j_q    <= '0;
      end else if (mac_en) begin
        i_q <= i_q + 2'd1;
        if (i_q == 2'd3) begin
          j_q         <= j_q + 2'd1;
          shadow[j_q] <= q_next;
        end
        // outputs land on entry to DONE so they are valid with ap_done
        if (last) begin
          ap_return_0 <= shadow[0];
          ap_return_1 <= shadow[1];
          ap_return_2 <= shadow[2];
          ap_return_3 <= q_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_dense_l2_seq.sv
// Directed bench for motor_dense_l2_seq: default, identity,
// identity+0.5 bias and wrap/truncate weight sets run in lockstep.
module tb_motor_dense_l2_seq;
  import motor_dense_l2_pkg::*;

  localparam logic [335:0] W_ID = {
    21'h04000, 21'h0, 21'h0, 21'h0,
    21'h0, 21'h04000, 21'h0, 21'h0,
    21'h0, 21'h0, 21'h04000, 21'h0,
    21'h0, 21'h0, 21'h0, 21'h04000
  };
  localparam logic [335:0] W_WR = {
    {7{21'h0}}, 21'h1FFFFF, {2{21'h0}},
    21'h1FFFFF, {4{21'h0}}, 21'h0FFFFF
  };
  localparam logic [83:0] B_ZERO = '0;
  localparam logic [83:0] B_HALF = {4{21'h02000}};

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic [20:0] p_read0 = '0;
  logic [20:0] p_read1 = '0;
  logic [20:0] p_read2 = '0;
  logic [20:0] p_read3 = '0;
  logic        rdy [4];
  logic        idl [4];
  logic        dn  [4];
  logic [20:0] ret [4][4];

  int pass = 0;
  int total = 0;

  always #5 ap_clk = ~ap_clk;

  motor_dense_l2_seq u_def (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_ready(rdy[0]), .ap_idle(idl[0]), .ap_done(dn[0]),
    .p_read0(p_read0), .p_read1(p_read1),
    .p_read2(p_read2), .p_read3(p_read3),
    .ap_return_0(ret[0][0]), .ap_return_1(ret[0][1]),
    .ap_return_2(ret[0][2]), .ap_return_3(ret[0][3])
  );

  motor_dense_l2_seq #(.WEIGHTS(W_ID), .BIASES(B_ZERO)) u_id (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_ready(rdy[1]), .ap_idle(idl[1]), .ap_done(dn[1]),
    .p_read0(p_read0), .p_read1(p_read1),
    .p_read2(p_read2), .p_read3(p_read3),
    .ap_return_0(ret[1][0]), .ap_return_1(ret[1][1]),
    .ap_return_2(ret[1][2]), .ap_return_3(ret[1][3])
  );

  motor_dense_l2_seq #(.WEIGHTS(W_ID), .BIASES(B_HALF)) u_idb (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_ready(rdy[2]), .ap_idle(idl[2]), .ap_done(dn[2]),
    .p_read0(p_read0), .p_read1(p_read1),
    .p_read2(p_read2), .p_read3(p_read3),
    .ap_return_0(ret[2][0]), .ap_return_1(ret[2][1]),
    .ap_return_2(ret[2][2]), .ap_return_3(ret[2][3])
  );

  motor_dense_l2_seq #(.WEIGHTS(W_WR), .BIASES(B_ZERO)) u_wr (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_ready(rdy[3]), .ap_idle(idl[3]), .ap_done(dn[3]),
    .p_read0(p_read0), .p_read1(p_read1),
    .p_read2(p_read2), .p_read3(p_read3),
    .ap_return_0(ret[3][0]), .ap_return_1(ret[3][1]),
    .ap_return_2(ret[3][2]), .ap_return_3(ret[3][3])
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  // one-cycle start from IDLE; returns cycle index at which done seen
  task automatic run(input logic [20:0] a, input logic [20:0] b,
                     input logic [20:0] c, input logic [20:0] d,
                     output int lat);
    p_read0 = a; p_read1 = b; p_read2 = c; p_read3 = d;
    ap_start = 1'b1;
    tick(1);
    ap_start = 1'b0;
    lat = 1;
    while (dn[0] !== 1'b1 && lat < 40) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic test_reset;
    int bad;
    ap_rst_n = 1'b0;
    tick(3);
    for (int u = 0; u < 4; u++) begin
      for (int j = 0; j < 4; j++) begin
        total++;
        if (ret[u][j] !== 21'h0)
          $display("FAIL reset_ret u%0d y%0d got %h want 0", u, j, ret[u][j]);
        else pass++;
      end
    end
    total++;
    if (idl[0] !== 1'b1 || dn[0] !== 1'b0)
      $display("FAIL reset_ctl idle=%b done=%b want 1/0", idl[0], dn[0]);
    else pass++;
    ap_rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (idl[0] !== 1'b1 || dn[0] !== 1'b0 || ret[0][0] !== 21'h0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL quiet_50 bad_cycles=%0d want 0", bad);
    else pass++;
  endtask

  task automatic test_zero;
    int lat;
    logic [83:0] bv;
    logic [20:0] bj;
    bv = BIASES_DEF;
    run(21'h0, 21'h0, 21'h0, 21'h0, lat);
    total++;
    if (lat != 17) $display("FAIL zero_latency got %0d want 17", lat);
    else pass++;
    for (int j = 0; j < 4; j++) begin
      bj = bv[j*21 +: 21];
      total++;
      if (ret[0][j] !== bj)
        $display("FAIL zero_bias y%0d got %h want %h", j, ret[0][j], bj);
      else pass++;
    end
    tick(1);
    total++;
    if (dn[0] !== 1'b0 || idl[0] !== 1'b1)
      $display("FAIL done_pulse done=%b idle=%b want 0/1", dn[0], idl[0]);
    else pass++;
    bj = bv[0 +: 21];
    total++;
    if (ret[0][0] !== bj)
      $display("FAIL hold_after_done got %h want %h", ret[0][0], bj);
    else pass++;
  endtask

  task automatic test_identity;
    int lat;
    logic [20:0] x [4];
    logic [20:0] yb [4];
    x[0] = 21'h04000; x[1] = 21'h08000; x[2] = 21'h00001; x[3] = 21'h0C000;
    yb[0] = 21'h06000; yb[1] = 21'h0A000; yb[2] = 21'h02001; yb[3] = 21'h0E000;
    run(x[0], x[1], x[2], x[3], lat);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (ret[1][j] !== x[j])
        $display("FAIL ident y%0d got %h want %h", j, ret[1][j], x[j]);
      else pass++;
      total++;
      if (ret[2][j] !== yb[j])
        $display("FAIL ident_bias y%0d got %h want %h", j, ret[2][j], yb[j]);
      else pass++;
    end
    tick(1);
  endtask

  task automatic test_wrap;
    int lat;
    logic [20:0] e1 [4];
    logic [20:0] e2 [4];
    // (2^20-1)^2 >> 14 wraps to -128 LSB; -(2^20-1) floors to -64 LSB
    e1[0] = 21'h1FFF80; e1[1] = 21'h0; e1[2] = 21'h1FFFC0; e1[3] = 21'h0;
    // -1 * 2^-28 truncates toward -inf to -1 LSB
    e2[0] = 21'h0; e2[1] = 21'h1FFFFF; e2[2] = 21'h0; e2[3] = 21'h0;
    run(21'h0FFFFF, 21'h0, 21'h0, 21'h0, lat);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (ret[3][j] !== e1[j])
        $display("FAIL wrap y%0d got %h want %h", j, ret[3][j], e1[j]);
      else pass++;
    end
    tick(1);
    run(21'h0, 21'h00001, 21'h0, 21'h0, lat);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (ret[3][j] !== e2[j])
        $display("FAIL trunc y%0d got %h want %h", j, ret[3][j], e2[j]);
      else pass++;
    end
    tick(1);
  endtask

  task automatic test_back_to_back;
    int acc_c, last_d, ndone, lat;
    int bad_lat, bad_iv, bad_val, bad_rdy;
    logic [20:0] ex [4];
    acc_c = 0; last_d = -1; ndone = 0;
    bad_lat = 0; bad_iv = 0; bad_val = 0; bad_rdy = 0;
    for (int j = 0; j < 4; j++) ex[j] = '0;
    ap_start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      p_read0 = 21'(c*4099 + 3);
      p_read1 = 21'(c*77777 + 11);
      p_read2 = 21'(~(c*1234));
      p_read3 = 21'(c << 12);
      #1;
      if (rdy[1] !== idl[1]) bad_rdy++;
      if (rdy[1] === 1'b1) begin
        acc_c = c;
        ex[0] = p_read0; ex[1] = p_read1;
        ex[2] = p_read2; ex[3] = p_read3;
      end
      if (dn[1] === 1'b1) begin
        ndone++;
        if (c - acc_c != 17) bad_lat++;
        if (last_d >= 0 && c - last_d != 18) bad_iv++;
        last_d = c;
        for (int j = 0; j < 4; j++)
          if (ret[1][j] !== ex[j]) bad_val++;
      end
      @(posedge ap_clk);
      #1;
    end
    ap_start = 1'b0;
    total++;
    if (ndone != 5) $display("FAIL b2b_count got %0d want 5", ndone);
    else pass++;
    total++;
    if (bad_lat != 0) $display("FAIL b2b_latency bad=%0d want 0", bad_lat);
    else pass++;
    total++;
    if (bad_iv != 0) $display("FAIL b2b_interval bad=%0d want 0", bad_iv);
    else pass++;
    total++;
    if (bad_val != 0) $display("FAIL b2b_values bad=%0d want 0", bad_val);
    else pass++;
    total++;
    if (bad_rdy != 0) $display("FAIL b2b_ready bad=%0d want 0", bad_rdy);
    else pass++;
    lat = 0;
    while (dn[1] !== 1'b1 && lat < 40) begin
      tick(1);
      lat++;
    end
    total++;
    if (lat >= 40) $display("FAIL drain_timeout waited %0d cycles", lat);
    else pass++;
    tick(1);
  endtask

  task automatic test_reset_midrun;
    int lat, seen;
    p_read0 = 21'h11111; p_read1 = 21'h0ABCD;
    p_read2 = 21'h1F000; p_read3 = 21'h00777;
    ap_start = 1'b1;
    tick(1);
    ap_start = 1'b0;
    tick(8);
    ap_rst_n = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      total++;
      if (ret[1][j] !== 21'h0)
        $display("FAIL midrst_ret y%0d got %h want 0", j, ret[1][j]);
      else pass++;
    end
    total++;
    if (idl[1] !== 1'b1) $display("FAIL midrst_idle got %b want 1", idl[1]);
    else pass++;
    seen = 0;
    for (int k = 0; k < 33; k++) begin
      if (k == 3) ap_rst_n = 1'b1;
      tick(1);
      if (dn[1] !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL midrst_nodone pulses=%0d want 0", seen);
    else pass++;
    run(21'h1ABCD, 21'h00F0F, 21'h13579, 21'h02468, lat);
    total++;
    if (lat != 17) $display("FAIL midrst_latency got %0d want 17", lat);
    else pass++;
    total++;
    if (ret[1][0] !== 21'h1ABCD || ret[1][1] !== 21'h00F0F ||
        ret[1][2] !== 21'h13579 || ret[1][3] !== 21'h02468)
      $display("FAIL midrst_rerun got %h %h %h %h want 1abcd 00f0f 13579 02468",
               ret[1][0], ret[1][1], ret[1][2], ret[1][3]);
    else pass++;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_identity();
    test_wrap();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
